alu_div_seq: RTL and testbench

Iterative radix-2 restoring divider with its own sequencing FSM and valid/ready handshakes. It serves all eight RV64M divide/remainder operations (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW) for the execute stage. It accepts one operation at a time and returns a final 64-bit result, sign-extended for W forms. Special cases finish in one cycle; all other operations take a fixed 64 or 32 iterations.

---
 rtl/alu_div_if.sv | 29 ++
 rtl/alu_div_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_div_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_div_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface alu_div_if #(
  parameter int XLEN = 64
);
  logic            div_valid_i;
  logic            div_ready_o;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            is_signed_i;
  logic            is_word_i;
  logic            is_rem_i;
  logic            flush_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport slave (
    input  div_valid_i, dividend_i, divisor_i, is_signed_i, is_word_i, is_rem_i,
           flush_i, res_ready_i,
    output div_ready_o, res_valid_o, result_o, busy_o
  );

  modport master (
    output div_valid_i, dividend_i, divisor_i, is_signed_i, is_word_i, is_rem_i,
           flush_i, res_ready_i,
    input  div_ready_o, res_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/alu_div_seq.sv
// Sequential radix-2 restoring divider for the RV64M divide/remainder family.
// One op in flight; divide-by-zero and overflow resolve at accept, others iterate 32 or 64 times.
module alu_div_seq #(
  parameter int XLEN = 64
) (
  input logic      clk,
  input logic      rst,
  alu_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [6:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] divisorAbs_q, divisorAbs_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;
  logic            isRem_q, isRem_d;
  logic            isWord_q, isWord_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] effA, effB, absA, absB, minNeg, specialRes;
  logic            signA, signB, divByZero, overflow, readyInt, accept;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] remNext, quoNext, picked, corrected;

  function automatic logic [XLEN-1:0] sextWord(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  assign readyInt        = (state_q == IDLE) & ~bus.flush_i;
  assign accept          = bus.div_valid_i & readyInt;
  assign bus.div_ready_o = readyInt;
  assign bus.res_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.result_o    = result_q;

  // Effective operands, magnitudes and the two early-out cases, all from the live request.
  always_comb begin
    effA = bus.dividend_i;
    effB = bus.divisor_i;
    if (bus.is_word_i) begin
      effA = bus.is_signed_i ? sextWord(bus.dividend_i) : {{(XLEN-32){1'b0}}, bus.dividend_i[31:0]};
      effB = bus.is_signed_i ? sextWord(bus.divisor_i)  : {{(XLEN-32){1'b0}}, bus.divisor_i[31:0]};
    end
    signA     = bus.is_signed_i & effA[XLEN-1];
    signB     = bus.is_signed_i & effB[XLEN-1];
    absA      = signA ? -effA : effA;
    absB      = signB ? -effB : effB;
    minNeg    = bus.is_word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    divByZero = (effB == '0);
    overflow  = bus.is_signed_i & (effA == minNeg) & (effB == '1);
    if (divByZero) begin
      specialRes = bus.is_rem_i ? effA : '1;
    end else begin
      specialRes = bus.is_rem_i ? '0 : effA;
    end
    if (bus.is_word_i) begin
      specialRes = sextWord(specialRes);
    end
  end

  // One restoring step; the 65-bit trial's top bit is the borrow that decides the quotient bit.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, divisorAbs_q};
    if (!trial[XLEN]) begin
      remNext = trial[XLEN-1:0];
      quoNext = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      remNext = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quoNext = {quo_q[XLEN-2:0], 1'b0};
    end
    picked    = isRem_q ? remNext : quoNext;
    corrected = (isRem_q ? negR_q : negQ_q) ? -picked : picked;
    if (isWord_q) begin
      corrected = sextWord(corrected);
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    divisorAbs_d = divisorAbs_q;
    negQ_d       = negQ_q;
    negR_d       = negR_q;
    isRem_d      = isRem_q;
    isWord_d     = isWord_q;
    result_d     = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          negQ_d   = signA ^ signB;
          negR_d   = signA;
          isRem_d  = bus.is_rem_i;
          isWord_d = bus.is_word_i;
          if (divByZero || overflow) begin
            result_d = specialRes;
            state_d  = DONE;
          end else begin
            count_d      = bus.is_word_i ? 7'd32 : 7'd64;
            rem_d        = '0;
            quo_d        = bus.is_word_i ? {absA[31:0], {(XLEN-32){1'b0}}} : absA;
            divisorAbs_d = absB;
            state_d      = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = remNext;
        quo_d   = quoNext;
        count_d = count_q - 7'd1;
        if (count_q == 7'd1) begin
          result_d = corrected;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A kill wins over every other transition and leaves no result behind.
    if (bus.flush_i) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      divisorAbs_q <= '0;
      negQ_q       <= 1'b0;
      negR_q       <= 1'b0;
      isRem_q      <= 1'b0;
      isWord_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      divisorAbs_q <= divisorAbs_d;
      negQ_q       <= negQ_d;
      negR_q       <= negR_d;
      isRem_q      <= isRem_d;
      isWord_q     <= isWord_d;
      result_q     <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: directed RV64M corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_div_seq;

  logic clk = 1'b0;
  logic rst;

  alu_div_if #(.XLEN(64)) bus ();

  alu_div_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } expect_t;

  expect_t     expQ[$];
  expect_t     cur;
  int          checkCnt = 0;
  int          passCnt  = 0;
  int          cycleCnt = 0;
  int          acceptAt = 0;
  bit          resSeen  = 1'b0;
  logic [63:0] heldResult;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCnt++;
    if (actual === expected) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  // Reference model: RV64M semantics written with the simulator's own signed/unsigned division.
  function automatic void refModel(input logic [63:0] a, input logic [63:0] b,
                                   input bit sgn, input bit word, input bit rem,
                                   output logic [63:0] res, output int lat);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    logic [31:0]     w;
    bit              special;
    special = 1'b0;
    if (word) begin
      if (sgn) begin
        sa32 = a[31:0];
        sb32 = b[31:0];
        if (sb32 == 0) begin
          special = 1'b1;
          w = rem ? sa32 : 32'hFFFF_FFFF;
        end else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
          special = 1'b1;
          w = rem ? 32'h0 : a[31:0];
        end else begin
          w = rem ? (sa32 % sb32) : (sa32 / sb32);
        end
      end else begin
        ua32 = a[31:0];
        ub32 = b[31:0];
        if (ub32 == 0) begin
          special = 1'b1;
          w = rem ? ua32 : 32'hFFFF_FFFF;
        end else begin
          w = rem ? (ua32 % ub32) : (ua32 / ub32);
        end
      end
      res = {{32{w[31]}}, w};
    end else begin
      if (sgn) begin
        sa = a;
        sb = b;
        if (sb == 0) begin
          special = 1'b1;
          res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
          special = 1'b1;
          res = rem ? 64'h0 : a;
        end else begin
          res = rem ? (sa % sb) : (sa / sb);
        end
      end else begin
        ua = a;
        ub = b;
        if (ub == 0) begin
          special = 1'b1;
          res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
          res = rem ? (ua % ub) : (ua / ub);
        end
      end
    end
    lat = special ? 1 : (word ? 33 : 65);
  endfunction

  function automatic logic [63:0] randOperand();
    logic [63:0] v;
    logic [31:0] lo;
    lo = $urandom;
    case ($urandom_range(0, 7))
      0:       v = 64'h0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'($urandom_range(1, 1000));
      5:       v = {32'hFFFF_FFFF, lo};
      default: v = {$urandom, lo};
    endcase
    return v;
  endfunction

  // Monitor: pops one expectation per result and watches DONE-state holding behaviour.
  always @(negedge clk) begin
    cycleCnt++;
    if (rst) begin
      resSeen = 1'b0;
    end else begin
      if (bus.res_valid_o && !resSeen) begin
        checkOutput("result expected", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
          cur = expQ.pop_front();
          checkOutput("result", bus.result_o, cur.res);
          checkOutput("latency", 64'(cycleCnt - acceptAt), 64'(cur.lat));
          checkOutput("busy in DONE", 64'(bus.busy_o), 64'd1);
        end
        resSeen    = 1'b1;
        heldResult = bus.result_o;
      end else if (bus.res_valid_o) begin
        checkOutput("result hold", bus.result_o, heldResult);
        checkOutput("ready low in DONE", 64'(bus.div_ready_o), 64'd0);
      end
      if (bus.res_valid_o && (bus.res_ready_i || bus.flush_i)) begin
        resSeen = 1'b0;
      end
      if (bus.div_valid_i && bus.div_ready_o) begin
        acceptAt = cycleCnt;
      end
    end
  end

  task automatic driveRequest(input logic [63:0] a, input logic [63:0] b,
                              input bit sgn, input bit word, input bit rem);
    int waitCnt = 0;
    while (!bus.div_ready_o && waitCnt < 300) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("ready before issue", 64'(bus.div_ready_o), 64'd1);
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.is_signed_i = sgn;
    bus.is_word_i   = word;
    bus.is_rem_i    = rem;
    bus.div_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.div_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input bit sgn, input bit word, input bit rem,
                               input logic [63:0] expRes, input int expLat, input int holdCycles);
    expect_t e;
    int      waitCnt = 0;
    e.res = expRes;
    e.lat = expLat;
    expQ.push_back(e);
    bus.res_ready_i = (holdCycles == 0);
    driveRequest(a, b, sgn, word, rem);
    while (!bus.res_valid_o && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("res_valid arrives", 64'(bus.res_valid_o), 64'd1);
    if (holdCycles > 0) begin
      repeat (holdCycles) begin
        @(posedge clk); #1;
      end
      bus.res_ready_i = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a, b, expRes;
    bit          sgn, word, rem;
    int          lat;

    rst             = 1'b1;
    bus.div_valid_i = 1'b0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.is_signed_i = 1'b0;
    bus.is_word_i   = 1'b0;
    bus.is_rem_i    = 1'b0;
    bus.flush_i     = 1'b0;
    bus.res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset res_valid", 64'(bus.res_valid_o), 64'd0);
    checkOutput("reset busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset result", bus.result_o, 64'd0);
    checkOutput("reset ready", 64'(bus.div_ready_o), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed and unsigned full-width and word ops through the iterative path
    applyStimulus(-64'sd7, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    applyStimulus(-64'sd7, 64'd2, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    applyStimulus(64'hFFFF_FFFF_8000_0000, 64'd1, 0, 1, 0, 64'hFFFF_FFFF_8000_0000, 33, 0);
    applyStimulus(64'd7, 64'd3, 0, 1, 1, 64'd1, 33, 0);

    // Divide-by-zero and signed overflow finish in one cycle
    applyStimulus(64'h123, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    applyStimulus(-64'sd5, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0);
    applyStimulus(64'h1_0000_0005, 64'd0, 1, 1, 1, 64'd5, 1, 0);
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 1, 0);
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 64'd0, 1, 0);
    applyStimulus(64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1, 0);

    // Backpressure then an immediate follow-on request
    applyStimulus(64'd1000, -64'sd10, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FF9C, 65, 10);
    checkOutput("ready after DONE release", 64'(bus.div_ready_o), 64'd1);
    applyStimulus(-64'sd20, 64'd3, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);

    // Flush in IDLE gates ready and swallows the request
    bus.flush_i     = 1'b1;
    bus.div_valid_i = 1'b1;
    bus.dividend_i  = 64'd50;
    bus.divisor_i   = 64'd5;
    #1;
    checkOutput("ready gated by flush", 64'(bus.div_ready_o), 64'd0);
    @(posedge clk); #1;
    bus.div_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    checkOutput("no accept during flush", 64'(bus.busy_o), 64'd0);

    // Flush at the 20th CALC iteration kills the op
    driveRequest(64'd1000, 64'd3, 0, 0, 0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    checkOutput("busy before flush", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    checkOutput("busy after flush", 64'(bus.busy_o), 64'd0);
    checkOutput("no result after flush", 64'(bus.res_valid_o), 64'd0);
    repeat (80) begin
      @(posedge clk); #1;
    end
    applyStimulus(64'd100, 64'd7, 0, 0, 0, 64'd14, 65, 0);

    // Asynchronous reset in the middle of CALC
    driveRequest(64'd12345, 64'd67, 0, 0, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset res_valid", 64'(bus.res_valid_o), 64'd0);
    checkOutput("async reset busy", 64'(bus.busy_o), 64'd0);
    checkOutput("async reset result", bus.result_o, 64'd0);
    checkOutput("async reset ready", 64'(bus.div_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized ops against the reference model, some with backpressure
    for (int i = 0; i < 40; i++) begin
      a    = randOperand();
      b    = randOperand();
      sgn  = 1'($urandom_range(0, 1));
      word = 1'($urandom_range(0, 1));
      rem  = 1'($urandom_range(0, 1));
      refModel(a, b, sgn, word, rem, expRes, lat);
      applyStimulus(a, b, sgn, word, rem, expRes, lat,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
